// File: rtl/fpu_shared_arbiter_if.sv
// FPU-side bus of the shared arbiter.
// master = arbiter, slave = FPU.
interface fpu_shared_arbiter_if #(
  parameter int unsigned C_OP    = 32,
  parameter int unsigned C_CMD   = 4,
  parameter int unsigned C_RM    = 3,
  parameter int unsigned C_PC    = 5,
  parameter int unsigned C_FFLAG = 5
) ();
  logic               fpu_en_o;
  logic [C_OP-1:0]    fpu_a_o;
  logic [C_OP-1:0]    fpu_b_o;
  logic [C_OP-1:0]    fpu_c_o;
  logic [C_CMD-1:0]   fpu_op_o;
  logic [C_RM-1:0]    fpu_rm_o;
  logic [C_PC-1:0]    fpu_prec_o;
  logic [C_OP-1:0]    fpu_result_i;
  logic               fpu_valid_i;
  logic [C_FFLAG-1:0] fpu_flags_i;
  logic               fpu_divsqrt_busy_i;

  modport master (
    output fpu_en_o, fpu_a_o, fpu_b_o, fpu_c_o,
    output fpu_op_o, fpu_rm_o, fpu_prec_o,
    input  fpu_result_i, fpu_valid_i,
    input  fpu_flags_i, fpu_divsqrt_busy_i
  );

  modport slave (
    input  fpu_en_o, fpu_a_o, fpu_b_o, fpu_c_o,
    input  fpu_op_o, fpu_rm_o, fpu_prec_o,
    output fpu_result_i, fpu_valid_i,
    output fpu_flags_i, fpu_divsqrt_busy_i
  );
endinterface

// File: rtl/fpu_shared_arbiter.sv
// Round-robin arbiter sharing one FPU among NUM_REQ cores.
// One operation in flight; watchdog aborts a stuck FPU.
module fpu_shared_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned C_OP     = 32,
  parameter int unsigned C_CMD    = 4,
  parameter int unsigned C_RM     = 3,
  parameter int unsigned C_PC     = 5,
  parameter int unsigned C_FFLAG  = 5,
  parameter logic [C_CMD-1:0] C_FPU_DIV_CMD  = C_CMD'(4),
  parameter logic [C_CMD-1:0] C_FPU_SQRT_CMD = C_CMD'(5),
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  input  logic [NUM_REQ*C_OP-1:0]   op_a_i,
  input  logic [NUM_REQ*C_OP-1:0]   op_b_i,
  input  logic [NUM_REQ*C_OP-1:0]   op_c_i,
  input  logic [NUM_REQ*C_CMD-1:0]  op_i,
  input  logic [NUM_REQ*C_RM-1:0]   rm_i,
  input  logic [NUM_REQ*C_PC-1:0]   prec_i,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [C_OP-1:0]           result_o,
  output logic [C_FFLAG-1:0]        flags_o,
  output logic                      timeout_o,
  fpu_shared_arbiter_if.master      fpu
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [C_FFLAG-1:0] FLAG_NV =
    {1'b1, {(C_FFLAG-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [C_OP-1:0]  a;
    logic [C_OP-1:0]  b;
    logic [C_OP-1:0]  c;
    logic [C_CMD-1:0] op;
    logic [C_RM-1:0]  rm;
    logic [C_PC-1:0]  prec;
  } fpu_req_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, owner_q;
  logic [IW-1:0]       sel_idx, scan_idx;
  logic                sel_vld;
  fpu_req_t            req_q, req_d;
  logic [CW-1:0]       cnt_q;
  logic                load, issue, is_divsqrt;
  logic [NUM_REQ-1:0]  gnt, rvalid;
  logic [C_OP-1:0]     result;
  logic [C_FFLAG-1:0]  flags;
  logic                tmo;

  // first requester at or after ptr_q, wrapping
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      scan_idx = IW'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!sel_vld && req_i[scan_idx]) begin
        sel_vld = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

  always_comb begin
    req_d.a    = op_a_i[sel_idx*C_OP +: C_OP];
    req_d.b    = op_b_i[sel_idx*C_OP +: C_OP];
    req_d.c    = op_c_i[sel_idx*C_OP +: C_OP];
    req_d.op   = op_i[sel_idx*C_CMD +: C_CMD];
    req_d.rm   = rm_i[sel_idx*C_RM +: C_RM];
    req_d.prec = prec_i[sel_idx*C_PC +: C_PC];
  end

  assign is_divsqrt = (req_q.op == C_FPU_DIV_CMD) ||
                      (req_q.op == C_FPU_SQRT_CMD);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    issue   = 1'b0;
    gnt     = '0;
    rvalid  = '0;
    result  = '0;
    flags   = '0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gnt[sel_idx] = 1'b1;
          load         = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (!(is_divsqrt && fpu.fpu_divsqrt_busy_i)) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (fpu.fpu_valid_i) begin
          rvalid[owner_q] = 1'b1;
          result          = fpu.fpu_result_i;
          flags           = fpu.fpu_flags_i;
          state_d         = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          rvalid[owner_q] = 1'b1;
          flags           = FLAG_NV;
          tmo             = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        owner_q <= sel_idx;
        req_q   <= req_d;
        ptr_q   <= (sel_idx == IW'(NUM_REQ - 1)) ?
                   '0 : sel_idx + 1'b1;
      end
      if (state_q == WAIT && state_d == WAIT)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
    end
  end

  // all visible outputs are forced quiet while reset is held
  assign gnt_o     = rst_ni ? gnt    : '0;
  assign rvalid_o  = rst_ni ? rvalid : '0;
  assign result_o  = rst_ni ? result : '0;
  assign flags_o   = rst_ni ? flags  : '0;
  assign timeout_o = rst_ni & tmo;

  assign fpu.fpu_en_o   = rst_ni & issue;
  assign fpu.fpu_a_o    = fpu.fpu_en_o ? req_q.a  : '0;
  assign fpu.fpu_b_o    = fpu.fpu_en_o ? req_q.b  : '0;
  assign fpu.fpu_c_o    = fpu.fpu_en_o ? req_q.c  : '0;
  assign fpu.fpu_op_o   = fpu.fpu_en_o ? req_q.op : '0;
  assign fpu.fpu_rm_o   = req_q.rm;
  assign fpu.fpu_prec_o = req_q.prec;

endmodule

// File: tb/tb_fpu_shared_arbiter.sv
// Bench for fpu_shared_arbiter: directed and random
// transactions against a transaction-level model.
module tb_fpu_shared_arbiter;

  localparam int N   = 4;
  localparam int TMO = 63;
  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] DIV  = 4'd4;
  localparam logic [3:0] SQRT = 4'd5;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [3:0]    req_i;
  logic [3:0]    gnt_o;
  logic [127:0]  op_a_i, op_b_i, op_c_i;
  logic [15:0]   op_i;
  logic [11:0]   rm_i;
  logic [19:0]   prec_i;
  logic [3:0]    rvalid_o;
  logic [31:0]   result_o;
  logic [4:0]    flags_o;
  logic          timeout_o;

  int n_cmp  = 0;
  int n_err  = 0;
  int rr_ptr = 0;

  always #5 clk = ~clk;

  fpu_shared_arbiter_if fif ();

  fpu_shared_arbiter dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .op_a_i    (op_a_i),
    .op_b_i    (op_b_i),
    .op_c_i    (op_c_i),
    .op_i      (op_i),
    .rm_i      (rm_i),
    .prec_i    (prec_i),
    .rvalid_o  (rvalid_o),
    .result_o  (result_o),
    .flags_o   (flags_o),
    .timeout_o (timeout_o),
    .fpu       (fif)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int g);
    logic [3:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic rand_slots();
    for (int k = 0; k < N; k++) begin
      op_a_i[k*32 +: 32] = $urandom;
      op_b_i[k*32 +: 32] = $urandom;
      op_c_i[k*32 +: 32] = $urandom;
      op_i[k*4 +: 4]     = 4'($urandom_range(0, 3));
      rm_i[k*3 +: 3]     = 3'($urandom);
      prec_i[k*5 +: 5]   = 5'($urandom);
    end
  endtask

  // one clock: check at negedge, return just after posedge
  task automatic cyc(input string tag,
                     input logic [3:0] e_gnt,
                     input logic [3:0] e_rv,
                     input logic [31:0] e_res,
                     input logic [4:0] e_flg,
                     input logic e_tmo,
                     input logic e_en,
                     input logic [31:0] ea,
                     input logic [31:0] eb,
                     input logic [31:0] ec,
                     input logic [3:0] eop,
                     input logic [2:0] erm,
                     input logic [4:0] epc);
    @(negedge clk);
    chk({tag, ".gnt"}, 64'(gnt_o), 64'(e_gnt));
    chk({tag, ".rvalid"}, 64'(rvalid_o), 64'(e_rv));
    chk({tag, ".result"}, 64'(result_o), 64'(e_res));
    chk({tag, ".flags"}, 64'(flags_o), 64'(e_flg));
    chk({tag, ".timeout"}, 64'(timeout_o), 64'(e_tmo));
    chk({tag, ".fpu_en"}, 64'(fif.fpu_en_o), 64'(e_en));
    chk({tag, ".fpu_a"}, 64'(fif.fpu_a_o), 64'(ea));
    chk({tag, ".fpu_b"}, 64'(fif.fpu_b_o), 64'(eb));
    chk({tag, ".fpu_c"}, 64'(fif.fpu_c_o), 64'(ec));
    chk({tag, ".fpu_op"}, 64'(fif.fpu_op_o), 64'(eop));
    if (e_en) begin
      chk({tag, ".fpu_rm"}, 64'(fif.fpu_rm_o), 64'(erm));
      chk({tag, ".fpu_prec"}, 64'(fif.fpu_prec_o), 64'(epc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag);
    cyc(tag, '0, '0, '0, '0, 1'b0, 1'b0,
        '0, '0, '0, '0, '0, '0);
  endtask

  // lat: WAIT cycle index carrying fpu_valid_i (<0: never)
  // abort_at: WAIT cycle index where reset is applied (<0: never)
  task automatic do_txn(input logic [3:0] mask,
                        input logic [3:0] cmd,
                        input int busy_n,
                        input int lat,
                        input int abort_at);
    int g;
    logic [31:0] ea, eb, ec, res;
    logic [2:0]  erm;
    logic [4:0]  epc, flg;
    bit isdiv;
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && mask[(rr_ptr + i) % N]) g = (rr_ptr + i) % N;
    rand_slots();
    op_i[g*4 +: 4] = cmd;
    ea  = op_a_i[g*32 +: 32];
    eb  = op_b_i[g*32 +: 32];
    ec  = op_c_i[g*32 +: 32];
    erm = rm_i[g*3 +: 3];
    epc = prec_i[g*5 +: 5];
    req_i = mask;
    fif.fpu_valid_i        = 1'($urandom);
    fif.fpu_divsqrt_busy_i = 1'b0;
    fif.fpu_result_i       = $urandom;
    fif.fpu_flags_i        = 5'($urandom);
    cyc("grant", onehot(g), '0, '0, '0, 1'b0, 1'b0,
        '0, '0, '0, '0, '0, '0);
    rr_ptr = (g + 1) % N;
    rand_slots();
    isdiv = (cmd == DIV) || (cmd == SQRT);
    if (isdiv) begin
      for (int b = 0; b < busy_n; b++) begin
        fif.fpu_divsqrt_busy_i = 1'b1;
        fif.fpu_valid_i        = 1'($urandom);
        quiet("issue_busy");
      end
      fif.fpu_divsqrt_busy_i = 1'b0;
    end else begin
      fif.fpu_divsqrt_busy_i = 1'($urandom);
    end
    fif.fpu_valid_i = 1'($urandom);
    cyc("issue", '0, '0, '0, '0, 1'b0, 1'b1,
        ea, eb, ec, cmd, erm, epc);
    for (int w = 0; w <= TMO; w++) begin
      fif.fpu_divsqrt_busy_i = 1'($urandom);
      fif.fpu_result_i       = $urandom;
      fif.fpu_flags_i        = 5'($urandom);
      if (w == abort_at) begin
        rst_ni          = 1'b0;
        fif.fpu_valid_i = 1'b1;
        quiet("abort_rst");
        rst_ni = 1'b1;
        req_i  = '0;
        quiet("stale_valid");
        fif.fpu_valid_i = 1'b0;
        rr_ptr = 0;
        return;
      end
      if (w == lat) begin
        res = fif.fpu_result_i;
        flg = fif.fpu_flags_i;
        fif.fpu_valid_i = 1'b1;
        cyc("result", '0, onehot(g), res, flg, 1'b0, 1'b0,
            '0, '0, '0, '0, '0, '0);
        fif.fpu_valid_i = 1'b0;
        return;
      end
      fif.fpu_valid_i = 1'b0;
      if (w == TMO) begin
        cyc("timeout", '0, onehot(g), '0, 5'b10000, 1'b1,
            1'b0, '0, '0, '0, '0, '0, '0);
        return;
      end
      quiet("wait");
    end
  endtask

  initial begin
    logic [3:0] m;
    rst_ni = 1'b0;
    req_i  = '1;
    rand_slots();
    fif.fpu_valid_i        = 1'b1;
    fif.fpu_divsqrt_busy_i = 1'b0;
    fif.fpu_result_i       = $urandom;
    fif.fpu_flags_i        = 5'h1f;
    repeat (3) quiet("reset");
    rst_ni = 1'b1;
    req_i  = '0;
    quiet("idle_noreq");
    fif.fpu_valid_i = 1'b0;

    repeat (5) do_txn(4'hF, ADD, 0, $urandom_range(0, 4), -1);
    do_txn(4'b0001, ADD, 0, 2, -1);
    do_txn(4'b0100, DIV, 5, 1, -1);
    do_txn(4'b0110, SQRT, 2, 0, -1);
    do_txn(4'b0010, DIV, 0, 3, -1);
    do_txn(4'b1010, ADD, 0, -1, -1);
    do_txn(4'b1000, 4'd2, 0, TMO - 1, -1);
    do_txn(4'b0101, 4'd3, 0, TMO, -1);

    repeat (24) begin
      m = 4'($urandom_range(1, 15));
      do_txn(m, 4'($urandom_range(0, 5)),
             $urandom_range(0, 3), $urandom_range(0, 8), -1);
    end

    do_txn(4'b1000, 4'd1, 0, -1, 3);
    do_txn(4'hF, ADD, 0, 1, -1);
    do_txn(4'hF, DIV, 1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
